// File: rtl/div_sweep_ctrl.sv
// Sweep sequencer for clk_div: steps the divisor from start to stop, holds each
// value for a programmed number of divided-clock edges, and resets the divider on every load.
module div_sweep_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DWELL_W    = 16,
  parameter int RST_CYCLES = 2,
  parameter int MIN_DIV    = 2,
  parameter int RESET_DIV  = 125
) (
  input  logic               ref_clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_start_div,
  input  logic [WIDTH-1:0]   cfg_stop_div,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_cont,
  input  logic               abort,
  input  logic               div_clk,
  output logic [WIDTH-1:0]   divisor_out,
  output logic               div_rst_n,
  output logic               busy,
  output logic               step_done,
  output logic               sweep_done,
  output logic               err
);

  localparam int                RC_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]   RC_LAST     = RC_W'(RST_CYCLES - 1);
  localparam logic [WIDTH-1:0]  MIN_DIV_V   = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0]  RESET_DIV_V = WIDTH'(RESET_DIV);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_start;
  logic [WIDTH-1:0]     r_stop;
  logic [WIDTH-1:0]     r_step;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_cont;
  logic                 r_up;
  logic [WIDTH-1:0]     r_cur;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [RC_W-1:0]      r_rst_cnt;
  logic                 r_div_q;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_div_rst_n;
  logic                 r_step_done;
  logic                 r_sweep_done;
  logic                 r_err;

  logic                 w_tick;
  logic                 w_accept;
  logic                 w_cfg_bad;
  logic                 w_load_ok;
  logic                 w_load_bad;
  logic                 w_load_last;
  logic [DWELL_W-1:0]   w_dwell_tgt;
  logic [DWELL_W:0]     w_cnt_inc;
  logic                 w_dwell_hit;
  logic                 w_at_stop;
  logic                 w_reload;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_next;
  logic [WIDTH-1:0]     w_load_div;

  assign w_tick      = div_clk & ~r_div_q;
  assign w_accept    = (r_state == S_IDLE) & cfg_valid;
  assign w_cfg_bad   = (cfg_start_div < MIN_DIV_V) | (cfg_stop_div < MIN_DIV_V) |
                       ((cfg_step == '0) & (cfg_start_div != cfg_stop_div));
  assign w_load_ok   = w_accept & ~w_cfg_bad;
  assign w_load_bad  = w_accept & w_cfg_bad;
  assign w_load_last = (r_rst_cnt == RC_LAST);
  assign w_dwell_tgt = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
  assign w_cnt_inc   = {1'b0, r_dwell_cnt} + (DWELL_W+1)'(1);
  assign w_dwell_hit = (r_state == S_RUN) & w_tick & (w_cnt_inc == {1'b0, w_dwell_tgt});
  assign w_at_stop   = (r_cur == r_stop);
  assign w_reload    = ~w_at_stop | r_cont;

  // One extra bit exposes carry/borrow so the last step clamps onto stop instead of wrapping.
  assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
  assign w_diff = {1'b0, r_cur} - {1'b0, r_step};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_stop;
    if (r_up) begin
      if (!w_sum[WIDTH] && (w_sum[WIDTH-1:0] <= r_stop)) w_next = w_sum[WIDTH-1:0];
    end else begin
      if (!w_diff[WIDTH] && (w_diff[WIDTH-1:0] >= r_stop)) w_next = w_diff[WIDTH-1:0];
    end
  end

  assign w_load_div = w_at_stop ? r_start : w_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_load_ok) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_load_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_dwell_hit) w_state_nxt = w_reload ? S_LOAD : S_DONE;
      end
      S_DONE:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or negedge rst) begin
    if (!rst) begin
      r_start      <= '0;
      r_stop       <= '0;
      r_step       <= '0;
      r_dwell      <= '0;
      r_cont       <= 1'b0;
      r_up         <= 1'b0;
      r_cur        <= '0;
      r_dwell_cnt  <= '0;
      r_rst_cnt    <= '0;
      r_div_q      <= 1'b0;
      r_divisor    <= RESET_DIV_V;
      r_div_rst_n  <= 1'b0;
      r_step_done  <= 1'b0;
      r_sweep_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_div_q      <= div_clk;
      r_step_done  <= 1'b0;
      r_sweep_done <= 1'b0;
      r_err        <= w_load_bad;
      case (r_state)
        S_IDLE: begin
          if (w_load_ok) begin
            r_start     <= cfg_start_div;
            r_stop      <= cfg_stop_div;
            r_step      <= cfg_step;
            r_dwell     <= cfg_dwell;
            r_cont      <= cfg_cont;
            r_up        <= (cfg_stop_div >= cfg_start_div);
            r_cur       <= cfg_start_div;
            r_divisor   <= cfg_start_div;
            r_div_rst_n <= 1'b0;
            r_rst_cnt   <= '0;
          end else begin
            r_div_rst_n <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort || w_load_last) begin
            r_div_rst_n <= 1'b1;
            r_dwell_cnt <= '0;
          end else begin
            r_rst_cnt   <= r_rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            r_div_rst_n <= 1'b1;
          end else if (w_dwell_hit) begin
            r_step_done <= 1'b1;
            if (w_reload) begin
              r_cur       <= w_load_div;
              r_divisor   <= w_load_div;
              r_div_rst_n <= 1'b0;
              r_rst_cnt   <= '0;
            end
          end else if (w_tick) begin
            r_dwell_cnt <= w_cnt_inc[DWELL_W-1:0];
          end
        end
        S_DONE: begin
          r_div_rst_n <= 1'b1;
          if (!abort) r_sweep_done <= 1'b1;
        end
        default: r_div_rst_n <= 1'b1;
      endcase
    end
  end

  assign cfg_ready   = (r_state == S_IDLE);
  assign busy        = (r_state == S_LOAD) | (r_state == S_RUN);
  assign divisor_out = r_divisor;
  assign div_rst_n   = r_div_rst_n;
  assign step_done   = r_step_done;
  assign sweep_done  = r_sweep_done;
  assign err         = r_err;

endmodule

// File: tb/tb_div_sweep_ctrl.sv
// Directed bench for div_sweep_ctrl: drives div_clk directly and logs divisor
// changes, div_rst_n low runs and pulses, comparing against hand-computed sequences.
module tb_div_sweep_ctrl;
  localparam int W  = 32;
  localparam int DW = 16;

  logic          ref_clk = 1'b0;
  logic          rst;
  logic          cfg_valid = 1'b0;
  logic          cfg_cont  = 1'b0;
  logic          abort     = 1'b0;
  logic          div_clk   = 1'b0;
  logic [W-1:0]  cfg_start_div = '0;
  logic [W-1:0]  cfg_stop_div  = '0;
  logic [W-1:0]  cfg_step      = '0;
  logic [DW-1:0] cfg_dwell     = '0;
  logic          cfg_ready;
  logic [W-1:0]  divisor_out;
  logic          div_rst_n;
  logic          busy;
  logic          step_done;
  logic          sweep_done;
  logic          err;

  div_sweep_ctrl dut (
    .ref_clk       (ref_clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_start_div (cfg_start_div),
    .cfg_stop_div  (cfg_stop_div),
    .cfg_step      (cfg_step),
    .cfg_dwell     (cfg_dwell),
    .cfg_cont      (cfg_cont),
    .abort         (abort),
    .div_clk       (div_clk),
    .divisor_out   (divisor_out),
    .div_rst_n     (div_rst_n),
    .busy          (busy),
    .step_done     (step_done),
    .sweep_done    (sweep_done),
    .err           (err)
  );

  always #5 ref_clk = ~ref_clk;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] seq[$];
  logic [W-1:0] exp_q[$];
  int           lows[$];
  logic [W-1:0] last_div;
  int           low_run;
  int           n_step;
  int           n_sweep;
  int           n_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    seq.delete();
    lows.delete();
    low_run  = 0;
    n_step   = 0;
    n_sweep  = 0;
    n_err    = 0;
    last_div = divisor_out;
  endtask

  // One ref_clk cycle: sample just after the edge, log events, then move div_clk.
  task automatic cycle();
    @(posedge ref_clk);
    #1;
    cfg_valid = 1'b0;
    abort     = 1'b0;
    if (divisor_out !== last_div) begin
      seq.push_back(divisor_out);
      last_div = divisor_out;
    end
    if (!div_rst_n) low_run++;
    else if (low_run > 0) begin
      lows.push_back(low_run);
      low_run = 0;
    end
    if (step_done)  n_step++;
    if (sweep_done) n_sweep++;
    if (err)        n_err++;
    div_clk = ~div_clk;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] st,
                      input logic [DW-1:0] dw, input logic c);
    cfg_start_div = s;
    cfg_stop_div  = e;
    cfg_step      = st;
    cfg_dwell     = dw;
    cfg_cont      = c;
    cfg_valid     = 1'b1;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    while (n_sweep == 0 && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_sweep_seen"}, n_sweep, 1);
    check({tag, "_idle"}, cfg_ready, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, seq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < seq.size()) check($sformatf("%s_div%0d", tag, i), seq[i], exp_q[i]);
    end
  endtask

  task automatic check_lows(input string tag, input int loads);
    check({tag, "_loads"}, lows.size(), loads);
    foreach (lows[i]) check($sformatf("%s_low%0d", tag, i), lows[i], 2);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!(busy && div_rst_n) && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_in_run"}, busy && div_rst_n, 1);
  endtask

  initial begin
    logic [W-1:0] d;
    int           saved;

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge ref_clk);
    #1;
    check("rst_div", divisor_out, 125);
    check("rst_divrst", div_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_pulses", {step_done, sweep_done, err}, 0);
    rst = 1'b1;
    clear_log();
    cycle();
    check("rel_divrst", div_rst_n, 1);

    // Up sweep 10 -> 16 by 3, dwell 2.
    clear_log();
    send(10, 16, 3, 2, 1'b0);
    cycle();
    check("t1_first_div", divisor_out, 10);
    check("t1_first_divrst", div_rst_n, 0);
    check("t1_first_busy", busy, 1);
    check("t1_first_ready", cfg_ready, 0);
    run_to_done("t1", 200);
    exp_q = '{32'd10, 32'd13, 32'd16};
    check_seq("t1");
    check_lows("t1", 3);
    check("t1_steps", n_step, 3);
    check("t1_final_div", divisor_out, 16);
    check("t1_final_divrst", div_rst_n, 1);
    cycle();
    check("t1_sweep_once", n_sweep, 1);

    // Down sweep with clamp onto 11.
    clear_log();
    send(20, 11, 4, 1, 1'b0);
    run_to_done("t2", 200);
    exp_q = '{32'd20, 32'd16, 32'd12, 32'd11};
    check_seq("t2");
    check_lows("t2", 4);
    check("t2_steps", n_step, 4);

    // Carry out of WIDTH must clamp to stop, not wrap.
    clear_log();
    send(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 1, 1'b0);
    run_to_done("t3", 200);
    exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
    check_seq("t3");
    check("t3_steps", n_step, 2);

    // Rejected descriptors.
    clear_log();
    send(10, 12, 0, 1, 1'b0);
    cycle();
    check("rej_step0_err", err, 1);
    check("rej_step0_ready", cfg_ready, 1);
    check("rej_step0_busy", busy, 0);
    check("rej_step0_div", divisor_out, 32'hFFFF_FFFF);
    check("rej_step0_divrst", div_rst_n, 1);
    cycle();
    check("rej_err_cleared", err, 0);
    send(1, 12, 1, 1, 1'b0);
    cycle();
    check("rej_start1_err", err, 1);
    check("rej_start1_ready", cfg_ready, 1);
    send(10, 1, 1, 1, 1'b0);
    cycle();
    check("rej_stop1_err", err, 1);
    check("rej_count", n_err, 3);
    check("rej_no_load", seq.size(), 0);

    // Abort in IDLE is ignored.
    abort = 1'b1;
    cycle();
    check("idle_abort_ready", cfg_ready, 1);
    check("idle_abort_div", divisor_out, 32'hFFFF_FFFF);

    // Zero step with start == stop is legal: one load, one dwell.
    clear_log();
    send(7, 7, 0, 0, 1'b0);
    cycle();
    check("eq_err", err, 0);
    check("eq_busy", busy, 1);
    run_to_done("eq", 200);
    exp_q = '{32'd7};
    check_seq("eq");
    check("eq_steps", n_step, 1);

    // Continuous sweep 4,6,4,6,... then abort mid-RUN.
    clear_log();
    send(4, 6, 2, 1, 1'b1);
    repeat (30) cycle();
    check("cont_len_ok", seq.size() >= 4, 1);
    exp_q = '{32'd4, 32'd6, 32'd4, 32'd6};
    for (int i = 0; i < 4; i++) begin
      if (i < seq.size()) check($sformatf("cont_div%0d", i), seq[i], exp_q[i]);
    end
    check("cont_no_sweep", n_sweep, 0);
    wait_run("cont_a");
    send(100, 100, 0, 1, 1'b0);
    cycle();
    check("busy_cfg_ignored", divisor_out == 100, 0);
    wait_run("cont_b");
    d     = divisor_out;
    saved = n_step;
    abort = 1'b1;
    cycle();
    check("abort_ready", cfg_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_div_held", divisor_out, d);
    check("abort_divrst", div_rst_n, 1);
    check("abort_no_step", step_done, 0);
    repeat (6) cycle();
    check("abort_steps_frozen", n_step, saved);
    check("abort_no_sweep", n_sweep, 0);
    check("abort_div_still", divisor_out, d);

    // Reset asserted mid-LOAD, then a fresh sweep.
    clear_log();
    send(10, 16, 3, 1, 1'b0);
    cycle();
    check("mid_load_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_div", divisor_out, 125);
    check("mid_rst_divrst", div_rst_n, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge ref_clk);
    #1 rst = 1'b1;
    clear_log();
    cycle();
    check("post_rst_divrst", div_rst_n, 1);
    send(5, 9, 2, 1, 1'b0);
    run_to_done("t6", 200);
    exp_q = '{32'd5, 32'd7, 32'd9};
    check_seq("t6");
    check("t6_steps", n_step, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
